// File: rtl/counter_pkg.sv
// Shared definitions for the parameterised counter: boundary-mode encodings
// and the ceiling-log2 helper used to size the prescaler.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_param_if.sv
// Control and status bundle of the parameterised counter; the master drives
// the controls and observes count/tc, the counter is the slave.
interface counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en, up, mode, load, load_val,
        input  count, tc
    );

    modport slave (
        input  en, up, mode, load, load_val,
        output count, tc
    );
endinterface

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick fires on every PRESCALE-th enabled cycle; the phase
// holds while en is low and is cleared by rst or clr.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int          PW   = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // With PRESCALE=1 the phase register is constant, so tick is just en.
    assign tick = en && ((PRESCALE == 1) || (pre_q == LAST));

endmodule

// File: rtl/counter_param.sv
// Parameterised up/down counter with wrap or saturate boundary behaviour,
// parallel load and a registered terminal-count pulse.
module counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input logic             clk,
    input logic             rst,
    counter_param_if.slave  bus
);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_bad_param
            $error("counter_param: illegal WIDTH/MODULUS/PRESCALE combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;
    logic             step;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.load),
        .tick (tick)
    );

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Returns {tc, next count} for one step; boundary steps raise tc.
    function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] c,
                                               input logic u, input mode_e m);
        logic [WIDTH-1:0] nxt;
        logic             at_edge;
        at_edge = u ? (c == MAXV) : (c == '0);
        if (at_edge) begin
            if (m == MODE_SAT) begin
                nxt = c;
            end else begin
                nxt = u ? '0 : MAXV;
            end
        end else begin
            nxt = u ? c + WIDTH'(1) : c - WIDTH'(1);
        end
        return {at_edge, nxt};
    endfunction

    assign step = tick && !bus.load;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = clamp_load(bus.load_val);
        end else if (step) begin
            {tc_d, count_d} = step_fn(count_q, bus.up, mode_e'(bus.mode));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;

endmodule

// File: doc/counter_param.md
COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter WIDTH, default 4: count register width in bits.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step; legal range >= 1.
REQ-004 Port clk  input  1  rising-edge clock; the only clock.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  count enable; also gates the prescaler.
REQ-007 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 Port mode  input  1  boundary mode: 0 = wrap (modulo), 1 = saturate.
REQ-009 Port load  input  1  synchronous parallel load strobe.
REQ-010 Port load_val  input  WIDTH  value loaded when load=1.
REQ-011 Port count  output  WIDTH  registered count value.
REQ-012 Port tc  output  1  registered terminal-count pulse.

Function
REQ-013 The block SHALL update state only on rising clk; priority is rst > load > step.
REQ-014 A step SHALL occur on an edge where en=1, load=0 and the prescaler is at PRESCALE-1; with PRESCALE=1 every enabled cycle is a step.
REQ-015 The prescaler SHALL advance only when en=1, wrap from PRESCALE-1 to 0, and hold its value when en=0.
REQ-016 Up step, count < MODULUS-1: count SHALL become count+1 and tc SHALL be 0.
REQ-017 Down step, count > 0: count SHALL become count-1 and tc SHALL be 0.
REQ-018 Wrap mode, up step at MODULUS-1: count SHALL become 0 and tc SHALL be 1.
REQ-019 Wrap mode, down step at 0: count SHALL become MODULUS-1 and tc SHALL be 1.
REQ-020 Saturate mode, up step at MODULUS-1 or down step at 0: count SHALL hold and tc SHALL be 1 on every such step.
REQ-021 tc SHALL be high for exactly the one cycle following the boundary step edge, coincident with the new count value; on all other cycles tc SHALL be 0.
REQ-022 up and mode SHALL be sampled only at the step edge; changing them between steps SHALL have no other effect.
REQ-023 Load: count SHALL become load_val if load_val <= MODULUS-1, otherwise MODULUS-1; the prescaler SHALL clear to 0; tc SHALL be 0; en is ignored.
REQ-024 en=0 with load=0: count and prescaler SHALL hold and tc SHALL be 0.
REQ-025 Arithmetic SHALL be WIDTH bits wide with no intermediate overflow; count SHALL never leave 0..MODULUS-1.
REQ-026 Illegal parameters (MODULUS < 2, MODULUS > 2**WIDTH, or PRESCALE < 1) SHALL cause an elaboration error.
REQ-027 With default parameters, en=1, up=1, mode=0 and load=0, the block SHALL behave as a free-running 4-bit up counter 0,1,...,15,0,...

Reset
REQ-028 While rst=1 at an edge: count SHALL become 0, the prescaler SHALL become 0 and tc SHALL become 0, regardless of load and en.
REQ-029 Reset asserted mid-prescale or mid-count SHALL discard the partial prescale; the first step after release SHALL occur PRESCALE enabled cycles later.
REQ-030 No initial-value statements SHALL be relied on; the state is defined only after the first reset edge.

Structure
REQ-031 The shared package counter_pkg SHALL hold the mode encodings MODE_WRAP=0 and MODE_SAT=1 and the ceiling-log2 function used for prescaler sizing.
REQ-032 The prescaler SHALL be a sub-module counter_prescaler (ports clk, rst, en, clr; output tick), instantiated once; with PRESCALE=1, tick SHALL equal en.
REQ-033 The counter datapath and tc register SHALL reside in counter_param; all outputs SHALL be registered.

Verification
REQ-034 Defaults, reset, then en=1/up=1/mode=0 for 20 cycles -> count 0..15, 0..3; tc=1 only in the cycle count=0 after 15.
REQ-035 MODULUS=10, down, wrap, start 0 -> count 9,8,...; tc=1 with count=9 after the step from 0.
REQ-036 mode=1, up, load_val=15, 3 steps -> count holds at 15; tc=1 for 3 consecutive cycles.
REQ-037 PRESCALE=4, en toggled 1,1,0,1,1 -> exactly one step, on the 4th enabled cycle.
REQ-038 MODULUS=10, load=1 with load_val=12 -> count=9; load and rst asserted together -> count=0.
REQ-039 rst asserted for one cycle mid-prescale (PRESCALE=4, prescaler=2) -> count=0, tc=0; next step 4 enabled cycles after release.
